// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per functional-unit source, a
// round-robin grant each cycle, and a registered broadcast to the RS/ROB.
package cdb_pkg;
    localparam int ROB_ID_W   = 4;
    localparam int CDB_WORD_W = 16;

    typedef logic [ROB_ID_W-1:0]   lc3b_rob_id;
    typedef logic [CDB_WORD_W-1:0] lc3b_word;

    localparam lc3b_rob_id ROB_ID_INVALID = '1;

    typedef struct packed {
        logic       ready;
        lc3b_rob_id dest;
        lc3b_word   value;
    } lc3b_cdb;

    localparam lc3b_cdb CDB_IDLE = '{ready: 1'b0, dest: ROB_ID_INVALID, value: '0};
endpackage

`ifndef REORDER_ID_INVALID
`define REORDER_ID_INVALID cdb_pkg::ROB_ID_INVALID
`endif

module cdb_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int WORD_W  = cdb_pkg::CDB_WORD_W
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 flush,
    input  logic [NUM_SRC-1:0]                   src_valid,
    input  cdb_pkg::lc3b_rob_id [NUM_SRC-1:0]    src_dest,
    input  logic [NUM_SRC-1:0][WORD_W-1:0]       src_value,
    output logic [NUM_SRC-1:0]                   src_ready,
    output cdb_pkg::lc3b_cdb                     data_bus
);
    import cdb_pkg::*;

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [PTR_W-1:0] LAST_SRC = PTR_W'(NUM_SRC - 1);

    logic [NUM_SRC-1:0] slot_occ;
    lc3b_rob_id         slot_dest  [NUM_SRC];
    logic [WORD_W-1:0]  slot_value [NUM_SRC];
    logic [PTR_W-1:0]   rr_ptr;

    logic               grant_vld;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W-1:0]   cand;
    logic [NUM_SRC-1:0] grant_mask;
    logic [NUM_SRC-1:0] load_en;

    // Rotating index starting at the round-robin pointer.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                  input int unsigned off);
        return PTR_W'((32'(base) + off) % NUM_SRC);
    endfunction

    // NOTE: every always_comb output gets a default first so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = wrap_add(rr_ptr, k);
            if (!grant_vld && slot_occ[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        grant_mask = grant_vld ? (NUM_SRC'(1) << grant_idx) : '0;
    end

    // A slot can take a new result if it is empty or being drained this cycle;
    // invalid-dest offers handshake but are never stored.
    always_comb begin
        src_ready = '0;
        load_en   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_ready[i] = !flush && (!slot_occ[i] || grant_mask[i]);
            load_en[i]   = src_valid[i] && src_ready[i] && (src_dest[i] != ROB_ID_INVALID);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop in
    // the block samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_occ <= '0;
            rr_ptr   <= '0;
            data_bus <= CDB_IDLE;
        end else if (flush) begin
            slot_occ <= '0;
            rr_ptr   <= '0;
            data_bus <= CDB_IDLE;
        end else begin
            slot_occ <= (slot_occ & ~grant_mask) | load_en;
            if (grant_vld) begin
                data_bus <= '{ready: 1'b1,
                              dest:  slot_dest[grant_idx],
                              value: lc3b_word'(slot_value[grant_idx])};
                rr_ptr   <= (grant_idx == LAST_SRC) ? '0 : grant_idx + 1'b1;
            end else begin
                data_bus <= CDB_IDLE;
            end
        end
    end

    // NOTE: slot payload is not reset; it is only ever read while its
    // occupied bit is set, and that bit is reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (load_en[i]) begin
                slot_dest[i]  <= src_dest[i];
                slot_value[i] <= src_value[i];
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomised and directed bench for cdb_arbiter against a slot/round-robin
// reference model plus an accepted-vs-broadcast conservation count.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int NUM = 4;
    localparam int WW  = 16;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   flush = 1'b0;
    logic [NUM-1:0]         src_valid = '0;
    lc3b_rob_id [NUM-1:0]   src_dest = '0;
    logic [NUM-1:0][WW-1:0] src_value = '0;
    logic [NUM-1:0]         src_ready;
    lc3b_cdb                data_bus;

    always #5 clk = ~clk;

    cdb_arbiter #(.NUM_SRC(NUM), .WORD_W(WW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .src_valid(src_valid), .src_dest(src_dest), .src_value(src_value),
        .src_ready(src_ready), .data_bus(data_bus)
    );

    int checks = 0;
    int failures = 0;

    // Reference: each source holds at most one pending result.
    bit         m_occ [NUM];
    lc3b_rob_id m_dest[NUM];
    logic [WW-1:0] m_val[NUM];
    int         m_rr;
    lc3b_cdb    m_bus;
    int         accepted;
    int         broadcast;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_winner();
        for (int k = 0; k < NUM; k++) begin
            if (m_occ[(m_rr + k) % NUM]) return (m_rr + k) % NUM;
        end
        return -1;
    endfunction

    function automatic logic [NUM-1:0] model_ready();
        logic [NUM-1:0] r;
        int w;
        w = model_winner();
        for (int i = 0; i < NUM; i++) r[i] = !flush && (!m_occ[i] || i == w);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM; i++) m_occ[i] = 1'b0;
        m_rr  = 0;
        m_bus = CDB_IDLE;
    endtask

    task automatic model_edge(input logic [NUM-1:0] rdy);
        int w;
        if (flush) begin
            model_reset();
            return;
        end
        w = model_winner();
        if (w >= 0) begin
            m_bus    = '{ready: 1'b1, dest: m_dest[w], value: m_val[w]};
            m_occ[w] = 1'b0;
            m_rr     = (w + 1) % NUM;
        end else begin
            m_bus = CDB_IDLE;
        end
        for (int i = 0; i < NUM; i++) begin
            if (src_valid[i] && rdy[i] && src_dest[i] != ROB_ID_INVALID) begin
                m_occ[i]  = 1'b1;
                m_dest[i] = src_dest[i];
                m_val[i]  = src_value[i];
                accepted++;
            end
        end
    endtask

    // Inputs are set by the caller; returns 1 time unit after the edge.
    task automatic tick();
        logic [NUM-1:0] rdy;
        #1;
        rdy = model_ready();
        check("src_ready", 64'(src_ready), 64'(rdy));
        @(posedge clk);
        model_edge(rdy);
        #1;
        check("data_bus", 64'(data_bus), 64'(m_bus));
        if (data_bus.ready) broadcast++;
    endtask

    task automatic idle();
        src_valid = '0;
        flush     = 1'b0;
    endtask

    task automatic offer(input int i, input lc3b_rob_id d, input logic [WW-1:0] v);
        src_valid[i] = 1'b1;
        src_dest[i]  = d;
        src_value[i] = v;
    endtask

    initial begin
        int src2_seen;
        int src2_tick;
        int ready_seen;

        model_reset();
        accepted  = 0;
        broadcast = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_bus", 64'(data_bus), 64'(CDB_IDLE));
        check("reset_src_ready", 64'(src_ready), 64'(4'hF));
        check("reset_rr_ptr", 64'(dut.rr_ptr), 64'(0));
        rst_n = 1'b1;
        idle();
        tick();

        // Single offer: one-cycle broadcast, then idle
        offer(0, 4'd3, 16'h1234);
        tick();
        idle();
        tick();
        check("single_bcast", 64'(data_bus), 64'({1'b1, 4'd3, 16'h1234}));
        tick();
        check("single_idle", 64'(data_bus), 64'(CDB_IDLE));

        // Contention from rr_ptr=0 (flush to re-home the pointer first)
        flush = 1'b1;
        tick();
        idle();
        for (int i = 0; i < NUM; i++) offer(i, lc3b_rob_id'(i + 1), 16'hA000 + 16'(i));
        tick();
        idle();
        for (int i = 0; i < NUM; i++) begin
            tick();
            check("contend_dest", 64'(data_bus.dest), 64'(i + 1));
            check("contend_ready", 64'(data_bus.ready), 64'(1));
        end
        check("contend_rr_wrap", 64'(dut.rr_ptr), 64'(0));
        tick();
        check("contend_idle", 64'(data_bus.ready), 64'(0));

        // Fairness: src0 streams, src2 offers once
        src2_seen = 0;
        src2_tick = -1;
        for (int j = 0; j < 8; j++) begin
            idle();
            offer(0, 4'd2, 16'h0100 + 16'(j));
            if (j == 1) offer(2, 4'd9, 16'hBEEF);
            tick();
            if (data_bus.ready && data_bus.dest == 4'd9) begin
                src2_seen++;
                src2_tick = j;
            end
        end
        idle();
        repeat (3) begin
            tick();
            if (data_bus.ready && data_bus.dest == 4'd9) src2_seen++;
        end
        check("fair_src2_once", 64'(src2_seen), 64'(1));
        check("fair_src2_latency", 64'(src2_tick >= 2 && src2_tick <= 3), 64'(1));

        // Flush with three slots occupied
        offer(0, 4'd5, 16'h5555);
        offer(1, 4'd6, 16'h6666);
        offer(2, 4'd7, 16'h7777);
        tick();
        idle();
        flush = 1'b1;
        tick();
        check("flush_bus_idle", 64'(data_bus), 64'(CDB_IDLE));
        idle();
        ready_seen = 0;
        repeat (4) begin
            tick();
            if (data_bus.ready) ready_seen++;
        end
        check("flush_no_leak", 64'(ready_seen), 64'(0));

        // Invalid destination is swallowed
        offer(1, ROB_ID_INVALID, 16'hDEAD);
        #1;
        check("inv_src_ready", 64'(src_ready[1]), 64'(1));
        tick();
        idle();
        ready_seen = 0;
        repeat (2) begin
            tick();
            if (data_bus.ready) ready_seen++;
        end
        check("inv_no_bcast", 64'(ready_seen), 64'(0));
        check("inv_slot_empty", 64'(dut.slot_occ), 64'(0));

        // Random traffic with occasional flush
        for (int c = 0; c < 300; c++) begin
            src_valid = NUM'($urandom);
            for (int i = 0; i < NUM; i++) begin
                src_dest[i]  = lc3b_rob_id'($urandom_range(0, 15));
                src_value[i] = WW'($urandom);
            end
            flush = ($urandom_range(0, 29) == 0);
            tick();
        end
        idle();
        repeat (6) tick();

        // Conservation: every accepted result broadcast exactly once
        accepted  = 0;
        broadcast = 0;
        for (int c = 0; c < 200; c++) begin
            src_valid = NUM'($urandom);
            for (int i = 0; i < NUM; i++) begin
                src_dest[i]  = lc3b_rob_id'($urandom_range(0, 15));
                src_value[i] = WW'($urandom);
            end
            flush = 1'b0;
            tick();
        end
        idle();
        repeat (NUM + 2) tick();
        check("conserve_count", 64'(broadcast), 64'(accepted));
        check("conserve_drained", 64'(dut.slot_occ), 64'(0));

        // Async reset mid-broadcast
        offer(1, 4'd4, 16'h4444);
        offer(3, 4'd5, 16'h5A5A);
        tick();
        idle();
        tick();
        check("areset_pre_ready", 64'(data_bus.ready), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_bus", 64'(data_bus), 64'(CDB_IDLE));
        check("areset_src_ready", 64'(src_ready), 64'(4'hF));
        check("areset_slots", 64'(dut.slot_occ), 64'(0));
        check("areset_rr_ptr", 64'(dut.rr_ptr), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
